input_bank: RTL and testbench
=============================

// Module: input_bank
// PURPOSE
// - Read-only memory-mapped input peripheral in the LSU's MA stage. Registers the board switches and push buttons.
// - Keeps a sticky button-event flag that the CPU clears through an ACK strobe.
// - Returns load data formatted per RISC-V funct3 (LB/LH/LW/LBU/LHU) to the LSU read mux.
// PARAMETERS
// - SW_W  32  switch bus width
// - BTN_W 4   button bus width
// PORTS
// - i_clk             in   1   system clock, rising edge
// - i_rst             in   1   reset, asynchronous, active-high
// - i_io_sw           in   32  raw switch levels
// - i_io_btn          in   4   raw button levels, 1 = pressed
// - i_lsu_addr        in   32  LSU byte address
// - i_lsu_wren        in   1   LSU store strobe
// - i_lsu_rden        in   1   LSU load strobe
// - o_ACK             in   1   flag-acknowledge strobe from the CPU; input despite its name
// - funct3            in   3   load type
// - input_buffer_out  out  32  formatted load data, combinational
// BEHAVIOUR
// - Reset clears sw_q, btn_q, btn_prev, evt_flag and evt_snap to 0, so input_buffer_out reads 0.
// - Every clock: sw_q<=i_io_sw; btn_q<=i_io_btn; btn_prev<=btn_q. A source change is readable 1 cycle later.
// - Edge detect: rise = btn_q & ~btn_prev.
//   - If rise != 0: evt_flag<=1 and evt_snap<=btn_q.
//   - Else if o_ACK: evt_flag<=0.
//   - Set wins over a simultaneous ACK. evt_snap holds until the next event.
// - Address decode: hit only when addr[31:16]==0. Region select uses addr[15:4]; addr[3:2] are ignored, so each region mirrors its word.
//   - 0x7000-0x700F  word = sw_q
//   - 0x7010-0x701F  word = {28'b0, btn_q}
//   - 0x7800-0x780F  word = {31'b0, evt_flag}
//   - 0x7810-0x781F  word = {28'b0, evt_snap}
//   - any other address: word = 0, no error.
// - Load formatting:
//   - byte = word[8*addr[1:0] +: 8]
//   - half = word[16*addr[1] +: 16]; addr[0] is ignored, so misaligned halves align down.
//   - 000 LB = sign-extended byte. 001 LH = sign-extended half. 010 LW = word; addr[1:0] ignored.
//   - 100 LBU = zero-extended byte. 101 LHU = zero-extended half.
//   - 011, 110, 111: output 0.
// - input_buffer_out = 0 unless i_lsu_rden=1, i_lsu_wren=0 and the address hits. Stores are ignored and never alter state.
// - Reads have no side effects: reading the flag does not clear it, only o_ACK does.
// - Reset asserted mid-operation clears all state immediately, including a pending flag.
// CONFIGURATION
// - INPUT_SYNC_EN defined:
//   - Two-flop synchronizer ahead of sw_q/btn_q.
//   - Input-to-read latency becomes 3 cycles; the edge detect runs on synchronized values.
// - INPUT_SYNC_EN undefined:
//   - Single register stage, 1-cycle latency.
//   - Inputs are assumed already synchronous to i_clk.
// STRUCTURE
// - Package input_bank_pkg holds:
//   - region base constants SW_BASE=16'h7000, BTN_BASE=16'h7010, FLAG_BASE=16'h7800, SNAP_BASE=16'h7810
//   - funct3 enum: LB, LH, LW, LBU, LHU
// - One sub-module, load_formatter: (word, addr[1:0], funct3) -> 32-bit result, purely combinational and reusable by other banks.
// - The top level holds the registers, edge detect, flag logic and address decode.
// TESTING
// - Bench runs with INPUT_SYNC_EN undefined; all read-back timings below assume the 1-cycle latency.
// - Switch reads:
//   - Setup: sw=32'h33221100, rden=1, wait 1 cycle.
//   - LW @0x7000 -> 32'h33221100. LBU @0x7002 -> 32'h00000022. LHU @0x7002 -> 32'h00003322.
// - Sign extension:
//   - Setup: sw=32'hA5B6C7D8.
//   - LB @0x7003 -> 32'hFFFFFFA5. LBU @0x7003 -> 32'h000000A5. LH @0x7000 -> 32'hFFFFC7D8.
// - Buttons:
//   - Setup: btn 0->4'h9.
//   - After 1 cycle: LBU @0x7010 -> 32'h00000009.
//   - After 2 cycles: LW @0x7800 -> 32'h1 and LW @0x7810 -> 32'h9. LBU @0x7802 -> 32'h0.
// - ACK:
//   - Pulse o_ACK for 1 cycle with no new edge; next cycle LW @0x7800 -> 0.
//   - Raise a new rise on the same cycle as o_ACK; the flag stays 1.
// - Gating:
//   - rden=0, or wren=1, or address 0x6000 -> output 0.
//   - funct3=3'b011 -> output 0.
//   - Stores never change any read value.
// - Reset:
//   - Assert i_rst asynchronously while the flag is set and sw is nonzero.
//   - Output goes to 0 immediately; the flag reads 0 after release.

Source files
------------

// File: rtl/input_bank_pkg.sv
// Shared constants and types for memory-mapped input banks.
// Holds region base addresses, the load-type encoding and the data width.
package input_bank_pkg;

  localparam int unsigned DATA_W = 32;

  // Region bases; only addr[15:4] participates in region select
  localparam logic [15:0] SW_BASE   = 16'h7000;
  localparam logic [15:0] BTN_BASE  = 16'h7010;
  localparam logic [15:0] FLAG_BASE = 16'h7800;
  localparam logic [15:0] SNAP_BASE = 16'h7810;

  // RISC-V load funct3 encodings
  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } funct3_e;

endpackage

// File: rtl/input_bank_load_formatter.sv
// Purely combinational RISC-V load formatter, reusable by any read-only bank.
// Ports:
//   word     - 32-bit source word of the selected region
//   addr_lo  - byte offset addr[1:0]
//   funct3   - load type (LB/LH/LW/LBU/LHU; anything else yields 0)
//   result_c - formatted load data
module load_formatter
  import input_bank_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        addr_lo,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] result_c
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Byte lane by addr[1:0]; half lane by addr[1] only, so misaligned halves align down
  always_comb begin
    byte_v = 8'(word >> {addr_lo, 3'b000});
    half_v = addr_lo[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    result_c = '0;
    case (funct3)
      F3_LB:   result_c = {{24{byte_v[7]}}, byte_v};
      F3_LH:   result_c = {{16{half_v[15]}}, half_v};
      F3_LW:   result_c = word;
      F3_LBU:  result_c = {24'b0, byte_v};
      F3_LHU:  result_c = {16'b0, half_v};
      default: result_c = '0;
    endcase
  end

endmodule

// File: rtl/input_bank.sv
// Read-only memory-mapped input peripheral (LSU MA stage).
// Registers switches and buttons, keeps a sticky button-event flag cleared by
// o_ACK, and returns funct3-formatted load data to the LSU read mux.
// Optional macro: INPUT_SYNC_EN adds a two-flop synchronizer ahead of sw_q/btn_q
// (3-cycle input-to-read latency); undefined gives a single stage (1 cycle).
// Ports:
//   i_clk, i_rst      - clock, async active-high reset
//   i_io_sw, i_io_btn - raw switch / button levels (1 = pressed)
//   i_lsu_addr        - LSU byte address
//   i_lsu_wren        - LSU store strobe (stores are ignored)
//   i_lsu_rden        - LSU load strobe
//   o_ACK             - flag-acknowledge input from the CPU
//   funct3            - load type
//   input_buffer_out  - combinational formatted load data
module input_bank
  import input_bank_pkg::*;
#(
  parameter int unsigned SW_W  = 32,
  parameter int unsigned BTN_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [SW_W-1:0]   i_io_sw,
  input  logic [BTN_W-1:0]  i_io_btn,
  input  logic [31:0]       i_lsu_addr,
  input  logic              i_lsu_wren,
  input  logic              i_lsu_rden,
  input  logic              o_ACK,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] input_buffer_out
);

  logic [SW_W-1:0]   sw_q;
  logic [BTN_W-1:0]  btn_q;
  logic [BTN_W-1:0]  btn_prev;
  logic              evt_flag;
  logic [BTN_W-1:0]  evt_snap;
  logic [BTN_W-1:0]  rise;
  logic [SW_W-1:0]   sw_src;
  logic [BTN_W-1:0]  btn_src;

  logic              hit;
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] fmt_data;
  logic              unused_addr;

`ifdef INPUT_SYNC_EN
  logic [SW_W-1:0]  sw_s1, sw_s2;
  logic [BTN_W-1:0] btn_s1, btn_s2;

  // Two-flop synchronizer for asynchronous board inputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
    end else begin
      sw_s1  <= i_io_sw;
      sw_s2  <= sw_s1;
      btn_s1 <= i_io_btn;
      btn_s2 <= btn_s1;
    end
  end

  assign sw_src  = sw_s2;
  assign btn_src = btn_s2;
`else
  assign sw_src  = i_io_sw;
  assign btn_src = i_io_btn;
`endif

  assign rise = btn_q & ~btn_prev;

  // Input registers, edge history and sticky event flag (set beats ACK)
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sw_q     <= '0;
      btn_q    <= '0;
      btn_prev <= '0;
      evt_flag <= 1'b0;
      evt_snap <= '0;
    end else begin
      sw_q     <= sw_src;
      btn_q    <= btn_src;
      btn_prev <= btn_q;
      if (|rise) begin
        evt_flag <= 1'b1;
        evt_snap <= btn_q;
      end else if (o_ACK) begin
        evt_flag <= 1'b0;
      end
    end
  end

  // Region decode on addr[15:4]; addr[3:2] ignored so each region mirrors its word
  always_comb begin
    hit  = 1'b0;
    word = '0;
    if (i_lsu_addr[31:16] == 16'h0) begin
      if (i_lsu_addr[15:4] == SW_BASE[15:4]) begin
        hit  = 1'b1;
        word = DATA_W'(sw_q);
      end else if (i_lsu_addr[15:4] == BTN_BASE[15:4]) begin
        hit  = 1'b1;
        word = DATA_W'(btn_q);
      end else if (i_lsu_addr[15:4] == FLAG_BASE[15:4]) begin
        hit  = 1'b1;
        word = DATA_W'(evt_flag);
      end else if (i_lsu_addr[15:4] == SNAP_BASE[15:4]) begin
        hit  = 1'b1;
        word = DATA_W'(evt_snap);
      end
    end
  end

  assign unused_addr = ^i_lsu_addr[3:2];

  load_formatter u_fmt (
    .word     (word),
    .addr_lo  (i_lsu_addr[1:0]),
    .funct3   (funct3),
    .result_c (fmt_data)
  );

  assign input_buffer_out = (i_lsu_rden && !i_lsu_wren && hit) ? fmt_data : '0;

endmodule

// File: tb/tb_input_bank.sv
// Directed self-checking bench for input_bank (single-stage input build).
module tb_input_bank;

  logic        clk;
  logic        rst;
  logic [31:0] sw;
  logic [3:0]  btn;
  logic [31:0] addr;
  logic        wren;
  logic        rden;
  logic        ack;
  logic [2:0]  f3;
  logic [31:0] dout;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  input_bank dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_io_sw          (sw),
    .i_io_btn         (btn),
    .i_lsu_addr       (addr),
    .i_lsu_wren       (wren),
    .i_lsu_rden       (rden),
    .o_ACK            (ack),
    .funct3           (f3),
    .input_buffer_out (dout)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [2:0] f,
                    input logic [31:0] exp);
    addr = a;
    f3   = f;
    #1;
    check(tag, dout, exp);
  endtask

  initial begin
    rst = 1'b1; sw = 32'hFFFF_FFFF; btn = 4'h0; addr = 32'h7000;
    wren = 1'b0; rden = 1'b1; ack = 1'b0; f3 = LW;
    step(2);
    rd("reset_sw", 32'h7000, LW, 32'h0);
    rd("reset_flag", 32'h7800, LW, 32'h0);
    #20 rst = 1'b0;

    // Switch reads
    sw = 32'h3322_1100;
    step(1);
    rd("sw_lw", 32'h7000, LW, 32'h3322_1100);
    rd("sw_lbu2", 32'h7002, LBU, 32'h0000_0022);
    rd("sw_lhu2", 32'h7002, LHU, 32'h0000_3322);
    rd("sw_mirror", 32'h700C, LW, 32'h3322_1100);
    rd("sw_lw_unal", 32'h7003, LW, 32'h3322_1100);

    // Sign extension
    sw = 32'hA5B6_C7D8;
    step(1);
    rd("lb3", 32'h7003, LB, 32'hFFFF_FFA5);
    rd("lbu3", 32'h7003, LBU, 32'h0000_00A5);
    rd("lh0", 32'h7000, LH, 32'hFFFF_C7D8);
    rd("lhu1_aligndown", 32'h7001, LHU, 32'h0000_C7D8);
    rd("lh3_aligndown", 32'h7003, LH, 32'hFFFF_A5B6);

    // Buttons and event flag
    btn = 4'h9;
    step(1);
    rd("btn_lbu", 32'h7010, LBU, 32'h0000_0009);
    rd("flag_not_yet", 32'h7800, LW, 32'h0);
    step(1);
    rd("flag_set", 32'h7800, LW, 32'h1);
    rd("snap", 32'h7810, LW, 32'h9);
    rd("flag_lbu2", 32'h7802, LBU, 32'h0);
    step(3);
    rd("flag_sticky", 32'h7800, LW, 32'h1);

    // Gating
    addr = 32'h7000; f3 = LW;
    rden = 1'b0; #1 check("rden0", dout, 32'h0);
    rden = 1'b1; wren = 1'b1; #1 check("wren1", dout, 32'h0);
    wren = 1'b0;
    rd("miss_6000", 32'h6000, LW, 32'h0);
    rd("miss_upper", 32'h1000_7000, LW, 32'h0);
    rd("f3_011", 32'h7000, 3'b011, 32'h0);
    rd("f3_110", 32'h7000, 3'b110, 32'h0);
    rd("f3_111", 32'h7000, 3'b111, 32'h0);

    // Stores never alter state
    addr = 32'h7800; wren = 1'b1;
    step(2);
    wren = 1'b0;
    rd("store_flag", 32'h7800, LW, 32'h1);
    rd("store_sw", 32'h7000, LW, 32'hA5B6_C7D8);

    // ACK clears flag; snapshot holds
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    rd("ack_clear", 32'h7800, LW, 32'h0);
    rd("snap_hold", 32'h7810, LW, 32'h9);

    // New rise coincident with ACK: set wins
    btn = 4'h0;
    step(2);
    btn = 4'h2;
    step(1);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    rd("set_beats_ack", 32'h7800, LW, 32'h1);
    rd("snap_new", 32'h7810, LW, 32'h2);

    // Asynchronous reset mid-operation
    rd("pre_reset_sw", 32'h7000, LW, 32'hA5B6_C7D8);
    btn = 4'h0;
    #20 rst = 1'b1;
    #1 check("async_rst_out", dout, 32'h0);
    #20 rst = 1'b0;
    rd("post_rst_flag", 32'h7800, LW, 32'h0);
    step(1);
    rd("post_rst_flag_clk", 32'h7800, LW, 32'h0);
    rd("post_rst_sw", 32'h7000, LW, 32'hA5B6_C7D8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
